// File: rtl/bird_draw.sv
// Bird sprite renderer.
// On each accepted go, the previously drawn 4x4 sprite is erased, and then the
// sprite is drawn at the newly latched row. A sprite that was never drawn since
// reset is not erased. The pixel stream (x, y, colour, plot) is registered.
// Each output register is loaded with the pixel for the state and count of the
// coming cycle, so the outputs line up with the state register.
module bird_draw #(
    parameter logic [7:0] BIRD_X   = 8'd20,
    parameter logic [6:0] Y_MAX    = 7'd116,
    parameter logic [2:0] COL_BIRD = 3'b010,
    parameter logic [2:0] COL_BG   = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [6:0] bird_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ERASE  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [6:0] new_y_reg, new_y_next;
    logic [6:0] old_y_reg;
    logic       drawn_valid_reg;
    logic [6:0] clamp_y;
    logic [6:0] base_next;
    logic       pixel_next;

    // Keep the whole 4-row sprite on the 120-row screen.
    assign clamp_y = (bird_y > Y_MAX) ? Y_MAX : bird_y;

    // Next-state, pixel counter and row-latch logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        new_y_next = new_y_reg;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    new_y_next = clamp_y;
                    cnt_next   = 4'd0;
                    state_next = drawn_valid_reg ? ERASE : DRAW;
                end
            end
            ERASE: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'hF) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'hF) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sprite origin row and plot enable for the pixel of the coming cycle.
    always_comb begin
        base_next  = (state_next == ERASE) ? old_y_reg : new_y_next;
        pixel_next = (state_next == ERASE) || (state_next == DRAW);
    end

    // State, counter and sprite-position registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            new_y_reg       <= 7'd0;
            old_y_reg       <= 7'd0;
            drawn_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            new_y_reg <= new_y_next;
            if (state_reg == FINISH) begin
                old_y_reg       <= new_y_reg;
                drawn_valid_reg <= 1'b1;
            end
        end
    end

    // Registered pixel stream; x/y/colour hold while no pixel is written.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
            done   <= 1'b0;
        end else begin
            plot <= pixel_next;
            done <= (state_next == FINISH);
            if (pixel_next) begin
                x      <= BIRD_X + {6'd0, cnt_next[1:0]};
                y      <= base_next + {5'd0, cnt_next[3:2]};
                colour <= (state_next == ERASE) ? COL_BG : COL_BIRD;
            end
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_bird_draw.sv
// Testbench for bird_draw: table-driven frames, random frames, and
// hand-written sequences for abort-by-reset and continuously held go.
module tb_bird_draw;

    logic       clk;
    logic       resetn;
    logic       go;
    logic [6:0] bird_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    // Reference model: whether a sprite is on screen, and its top row.
    bit         m_valid;
    logic [6:0] m_old;

    typedef struct {
        logic [6:0] by;
        logic [6:0] row;
    } vec_t;

    vec_t tbl[8];

    bird_draw dut (
        .clk    (clk),
        .resetn (resetn),
        .go     (go),
        .bird_y (bird_y),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_clamp(input logic [6:0] v);
        return (v > 7'd116) ? 7'd116 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: pulse go with by, re-pulse go mid-frame and change bird_y
    // to mid_y, then check every pixel against the model's sprite list.
    task automatic run_frame(input logic [6:0] by, input logic [6:0] row,
                             input logic [6:0] mid_y);
        int nb, np, nd, done_at, exp_busy, exp_plots;
        int j, er_row, col, xe, ye;
        bit erase;
        exp_busy  = m_valid ? 33 : 17;
        exp_plots = m_valid ? 32 : 16;
        nb = 0; np = 0; nd = 0; done_at = -1;
        @(negedge clk);
        go = 1'b1;
        bird_y = by;
        @(negedge clk);
        go = 1'b0;
        for (int c = 0; c < 45; c++) begin
            if (!busy) break;
            nb++;
            if (plot) begin
                erase = m_valid && (np < 16);
                j = (m_valid && np >= 16) ? np - 16 : np;
                er_row = erase ? int'(m_old) : int'(row);
                col = erase ? 0 : 2;
                xe = 20 + (j % 4);
                ye = er_row + (j / 4);
                check(erase ? "erase_pixel" : "draw_pixel",
                      int'({x, y, colour}), (xe << 10) | (ye << 3) | col);
                np++;
            end
            if (done) begin
                nd++;
                done_at = nb;
            end
            go = (c == 3);
            if (c == 1) bird_y = mid_y;
            @(negedge clk);
        end
        go = 1'b0;
        check("busy_cycles", nb, exp_busy);
        check("plot_cycles", np, exp_plots);
        check("done_count", nd, 1);
        check("done_position", done_at, exp_busy);
        check("idle_quiet", int'({busy, plot, done}), 0);
        $display("[TB] frame bird_y=%0d row=%0d busy=%0d plots=%0d", by, row, nb, np);
        m_valid = 1'b1;
        m_old = row;
    endtask

    initial begin
        int run_len, idle_len, runs, dones;
        bit ended;
        logic [6:0] rb;
        n_tests = 0;
        n_fail  = 0;
        m_valid = 1'b0;
        m_old   = 7'd0;
        go      = 1'b0;
        bird_y  = 7'd0;
        resetn  = 1'b0;

        tbl[0] = '{7'd40,  7'd40};
        tbl[1] = '{7'd50,  7'd50};
        tbl[2] = '{7'd127, 7'd116};
        tbl[3] = '{7'd20,  7'd20};
        tbl[4] = '{7'd117, 7'd116};
        tbl[5] = '{7'd0,   7'd0};
        tbl[6] = '{7'd0,   7'd0};
        tbl[7] = '{7'd116, 7'd116};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({x, y, colour, plot, busy, done}), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_reset_idle", int'({busy, plot, done}), 0);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].by, tbl[i].row, 7'd10);
        end

        // Random frames against the model.
        for (int i = 0; i < 12; i++) begin
            rb = 7'($urandom_range(0, 127));
            run_frame(rb, ref_clamp(rb), 7'($urandom_range(0, 127)));
        end

        // Reset in the middle of DRAW aborts at once; next frame is draw-only.
        @(negedge clk);
        go = 1'b1;
        bird_y = 7'd30;
        @(negedge clk);
        go = 1'b0;
        repeat (23) @(negedge clk);
        check("mid_draw_before_reset", int'({plot, busy, colour}), 5'b11010);
        #2 resetn = 1'b0;
        #1 check("abort_on_reset", int'({plot, busy, done}), 0);
        @(negedge clk);
        resetn = 1'b1;
        m_valid = 1'b0;
        $display("[TB] reset asserted mid-draw");
        run_frame(7'd60, 7'd60, 7'd60);

        // go held high continuously: back-to-back 33-cycle frames, 1 idle gap.
        @(negedge clk);
        go = 1'b1;
        bird_y = 7'd70;
        run_len = 0; idle_len = 0; runs = 0; dones = 0; ended = 1'b0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (busy) begin
                if (run_len == 0 && runs > 0) check("held_go_gap", idle_len, 1);
                run_len++;
                idle_len = 0;
            end else begin
                if (run_len > 0) begin
                    check("held_go_frame_len", run_len, 33);
                    runs++;
                end
                run_len = 0;
                idle_len++;
            end
            if (done) dones++;
            if (c == 99) go = 1'b0;
            if (c >= 100 && !busy) begin
                ended = 1'b1;
                break;
            end
        end
        go = 1'b0;
        check("held_go_ended", int'(ended), 1);
        check("held_go_frames", runs, 3);
        check("held_go_dones", dones, runs);
        $display("[TB] held go: frames=%0d dones=%0d", runs, dones);
        m_valid = 1'b1;
        m_old = ref_clamp(7'd70);

        // The held-go sprite at row 70 must be erased by the next frame.
        run_frame(7'd5, 7'd5, 7'd90);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
